crossbar_arbiter: RTL and testbench

Round-robin scheduler for the 4x4 packet crossbar `switch`. Each of the four input ports raises a request carrying a 2-bit destination output and a packet length. The block grants each output to at most one input at a time and holds that grant for the whole packet. It drives the per-output source selects that configure the crossbar datapath. It sits between the input-port queues and the crossbar and is the only agent allowed to change crossbar routing.

---
 rtl/crossbar_arbiter.sv | 132 +++++++++++++
 tb/tb_crossbar_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_arbiter.sv
// Round-robin scheduler for the 4x4 packet crossbar: one owner per output,
// held for the whole packet, with zero-bubble hand-over between packets.
module crossbar_arbiter #(
  parameter int NPORT = 4,
  parameter int LEN_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  input  logic [1:0]       dest0,
  input  logic [1:0]       dest1,
  input  logic [1:0]       dest2,
  input  logic [1:0]       dest3,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [LEN_W-1:0] len2,
  input  logic [LEN_W-1:0] len3,
  output logic [NPORT-1:0] gnt,
  output logic [1:0]       osel0,
  output logic [1:0]       osel1,
  output logic [1:0]       osel2,
  output logic [1:0]       osel3,
  output logic [NPORT-1:0] ovalid,
  output logic             busy
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state_q [NPORT];
  state_t           state_d [NPORT];
  logic [1:0]       owner_q [NPORT];
  logic [1:0]       owner_d [NPORT];
  logic [LEN_W-1:0] cnt_q   [NPORT];
  logic [LEN_W-1:0] cnt_d   [NPORT];
  logic [1:0]       ptr_q   [NPORT];
  logic [1:0]       ptr_d   [NPORT];

  logic [1:0]       dest_a  [NPORT];
  logic [LEN_W-1:0] len_a   [NPORT];
  logic [NPORT-1:0] cand    [NPORT];
  logic [2:0]       pick    [NPORT];
  logic [NPORT-1:0] gnt_d;
  logic [NPORT-1:0] ovalid_d;

  // Returns {found, winner}: first set bit of c scanning upward from p, wrapping.
  function automatic logic [2:0] rr_pick(input logic [NPORT-1:0] c, input logic [1:0] p);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = NPORT - 1; k >= 0; k--) begin
      idx = p + 2'(k);
      if (c[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign dest_a[0] = dest0;
  assign dest_a[1] = dest1;
  assign dest_a[2] = dest2;
  assign dest_a[3] = dest3;
  assign len_a[0]  = len0;
  assign len_a[1]  = len1;
  assign len_a[2]  = len2;
  assign len_a[3]  = len3;

  // An input holding a grant is masked so a held req only re-arms after gnt falls.
  always_comb begin
    for (int j = 0; j < NPORT; j++) begin
      for (int i = 0; i < NPORT; i++) begin
        cand[j][i] = req[i] && (dest_a[i] == 2'(j)) && !gnt[i];
      end
      pick[j] = rr_pick(cand[j], ptr_q[j]);
    end
  end

  always_comb begin
    gnt_d    = '0;
    ovalid_d = '0;
    for (int j = 0; j < NPORT; j++) begin
      state_d[j] = state_q[j];
      owner_d[j] = owner_q[j];
      cnt_d[j]   = cnt_q[j];
      ptr_d[j]   = ptr_q[j];
      if (state_q[j] == XFER && cnt_q[j] != '0) begin
        cnt_d[j] = cnt_q[j] - LEN_W'(1);
      end else if (pick[j][2]) begin
        // Idle or last flit: reload straight into the next packet.
        state_d[j] = XFER;
        owner_d[j] = pick[j][1:0];
        cnt_d[j]   = len_a[pick[j][1:0]];
        ptr_d[j]   = pick[j][1:0] + 2'd1;
      end else begin
        state_d[j] = IDLE;
      end
      if (state_d[j] == XFER) begin
        ovalid_d[j]         = 1'b1;
        gnt_d[owner_d[j]]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NPORT; j++) begin
        state_q[j] <= IDLE;
        owner_q[j] <= 2'd0;
        cnt_q[j]   <= '0;
        ptr_q[j]   <= 2'd0;
      end
      gnt    <= '0;
      ovalid <= '0;
      busy   <= 1'b0;
    end else begin
      for (int j = 0; j < NPORT; j++) begin
        state_q[j] <= state_d[j];
        owner_q[j] <= owner_d[j];
        cnt_q[j]   <= cnt_d[j];
        ptr_q[j]   <= ptr_d[j];
      end
      gnt    <= gnt_d;
      ovalid <= ovalid_d;
      busy   <= |ovalid_d;
    end
  end

  // The owner register only changes on a new grant, so it doubles as the held select.
  assign osel0 = owner_q[0];
  assign osel1 = owner_q[1];
  assign osel2 = owner_q[2];
  assign osel3 = owner_q[3];

endmodule

// File: tb/tb_crossbar_arbiter.sv
// Scoreboard bench for crossbar_arbiter: per-cycle expected outputs are queued
// as each stimulus cycle is driven and popped once the DUT has clocked it.
module tb_crossbar_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [1:0] dest0 = '0, dest1 = '0, dest2 = '0, dest3 = '0;
  logic [1:0] len0 = '0, len1 = '0, len2 = '0, len3 = '0;
  logic [3:0] gnt;
  logic [1:0] osel0, osel1, osel2, osel3;
  logic [3:0] ovalid;
  logic       busy;
  logic [7:0] osel_all;

  typedef struct {
    logic [3:0] g;
    logic [3:0] v;
    logic [7:0] s;
    logic [7:0] m;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  crossbar_arbiter dut (
    .clk(clk), .rst(rst), .req(req),
    .dest0(dest0), .dest1(dest1), .dest2(dest2), .dest3(dest3),
    .len0(len0), .len1(len1), .len2(len2), .len3(len3),
    .gnt(gnt),
    .osel0(osel0), .osel1(osel1), .osel2(osel2), .osel3(osel3),
    .ovalid(ovalid), .busy(busy)
  );

  assign osel_all = {osel3, osel2, osel1, osel0};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    sb.push_back(exp_t'{4'b0000, 4'b0000, 8'h00, 8'hFF});
    e = sb.pop_front();
    checks++;
    if (gnt !== e.g || ovalid !== e.v || busy !== (|e.v)) begin
      errors++;
      $display("[TB] FAIL reset gnt/ovalid/busy got %b/%b/%b want %b/%b/%b", gnt, ovalid, busy, e.g, e.v, |e.v);
    end
    checks++;
    if ((osel_all & e.m) !== (e.s & e.m)) begin
      errors++;
      $display("[TB] FAIL reset osel got %h want %h", osel_all, e.s);
    end
    rst = 1'b1;
    dest0 = 2'd1; dest1 = 2'd2; dest2 = 2'd3; dest3 = 2'd0;
    req = 4'b1111;
    sb.push_back(exp_t'{4'b0000, 4'b0000, 8'h00, 8'hFF});
    tick();
    e = sb.pop_front();
    checks++;
    if (gnt !== e.g || ovalid !== e.v || busy !== (|e.v)) begin
      errors++;
      $display("[TB] FAIL reset_held gnt/ovalid/busy got %b/%b/%b want %b/%b/%b", gnt, ovalid, busy, e.g, e.v, |e.v);
    end
    req = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] rq [3];
    logic [3:0] eg [3];
    logic [3:0] ev [3];
    exp_t e;
    rq = '{4'b0001, 4'b0000, 4'b0000};
    eg = '{4'b0001, 4'b0000, 4'b0000};
    ev = '{4'b0100, 4'b0000, 4'b0000};
    do_reset();
    dest0 = 2'd2; len0 = 2'd0;
    for (int c = 0; c < 3; c++) begin
      req = rq[c];
      sb.push_back(exp_t'{eg[c], ev[c], 8'h00, 8'h30});
      tick();
      e = sb.pop_front();
      checks++;
      if (gnt !== e.g || ovalid !== e.v || busy !== (|e.v)) begin
        errors++;
        $display("[TB] FAIL single c%0d gnt/ovalid/busy got %b/%b/%b want %b/%b/%b", c + 1, gnt, ovalid, busy, e.g, e.v, |e.v);
      end
      checks++;
      if ((osel_all & e.m) !== (e.s & e.m)) begin
        errors++;
        $display("[TB] FAIL single c%0d osel got %h want %h (mask %h)", c + 1, osel_all, e.s, e.m);
      end
    end
  endtask

  task automatic test_contention();
    logic [3:0] rq [10];
    logic [3:0] eg [10];
    logic [3:0] ev [10];
    logic [7:0] es [10];
    exp_t e;
    rq = '{4'b1011, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0011, 4'b0010, 4'b0000};
    eg = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0010, 4'b0000};
    ev = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
    es = '{8'h00, 8'h00, 8'h04, 8'h04, 8'h0C, 8'h0C, 8'h0C, 8'h00, 8'h04, 8'h04};
    do_reset();
    dest0 = 2'd1; dest1 = 2'd1; dest3 = 2'd1;
    len0 = 2'd1; len1 = 2'd1; len3 = 2'd1;
    for (int c = 0; c < 10; c++) begin
      // Cycles 7+ probe that the pointer wrapped back to input 0.
      if (c == 7) begin
        len0 = 2'd0;
        len1 = 2'd0;
      end
      req = rq[c];
      sb.push_back(exp_t'{eg[c], ev[c], es[c], 8'h0C});
      tick();
      e = sb.pop_front();
      checks++;
      if (gnt !== e.g || ovalid !== e.v || busy !== (|e.v)) begin
        errors++;
        $display("[TB] FAIL contention c%0d gnt/ovalid/busy got %b/%b/%b want %b/%b/%b", c + 1, gnt, ovalid, busy, e.g, e.v, |e.v);
      end
      checks++;
      if ((osel_all & e.m) !== (e.s & e.m)) begin
        errors++;
        $display("[TB] FAIL contention c%0d osel got %h want %h (mask %h)", c + 1, osel_all, e.s, e.m);
      end
    end
  endtask

  task automatic test_permutation();
    logic [3:0] rq [6];
    logic [3:0] eg [6];
    exp_t e;
    rq = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    eg = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
    do_reset();
    dest0 = 2'd3; dest1 = 2'd2; dest2 = 2'd1; dest3 = 2'd0;
    len0 = 2'd3; len1 = 2'd3; len2 = 2'd3; len3 = 2'd3;
    for (int c = 0; c < 6; c++) begin
      req = rq[c];
      sb.push_back(exp_t'{eg[c], eg[c], 8'h1B, 8'hFF});
      tick();
      e = sb.pop_front();
      checks++;
      if (gnt !== e.g || ovalid !== e.v || busy !== (|e.v)) begin
        errors++;
        $display("[TB] FAIL permutation c%0d gnt/ovalid/busy got %b/%b/%b want %b/%b/%b", c + 1, gnt, ovalid, busy, e.g, e.v, |e.v);
      end
      checks++;
      if ((osel_all & e.m) !== (e.s & e.m)) begin
        errors++;
        $display("[TB] FAIL permutation c%0d osel got %h want %h", c + 1, osel_all, e.s);
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] eg;
    logic [3:0] ev;
    logic [7:0] es;
    exp_t e;
    do_reset();
    dest0 = 2'd0; dest2 = 2'd0; len0 = 2'd0; len2 = 2'd0;
    for (int c = 0; c < 10; c++) begin
      req = (c < 8) ? 4'b0101 : 4'b0000;
      if (c < 8) begin
        eg = (c % 2 == 0) ? 4'b0001 : 4'b0100;
        ev = 4'b0001;
        es = (c % 2 == 0) ? 8'h00 : 8'h02;
      end else begin
        eg = 4'b0000;
        ev = 4'b0000;
        es = 8'h02;
      end
      sb.push_back(exp_t'{eg, ev, es, 8'h03});
      tick();
      e = sb.pop_front();
      checks++;
      if (gnt !== e.g || ovalid !== e.v || busy !== (|e.v)) begin
        errors++;
        $display("[TB] FAIL fairness c%0d gnt/ovalid/busy got %b/%b/%b want %b/%b/%b", c + 1, gnt, ovalid, busy, e.g, e.v, |e.v);
      end
      checks++;
      if ((osel_all & e.m) !== (e.s & e.m)) begin
        errors++;
        $display("[TB] FAIL fairness c%0d osel got %h want %h (mask %h)", c + 1, osel_all, e.s, e.m);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [3:0] rq [6];
    logic       rr [6];
    logic [3:0] eg [6];
    logic [3:0] ev [6];
    logic [7:0] es [6];
    exp_t e;
    rq = '{4'b0010, 4'b0000, 4'b0000, 4'b1010, 4'b1000, 4'b0000};
    rr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    eg = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b1000, 4'b0000};
    ev = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    es = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h03, 8'h03};
    do_reset();
    dest1 = 2'd0; len1 = 2'd3; dest3 = 2'd0; len3 = 2'd0;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) len1 = 2'd0;
      rst = rr[c];
      req = rq[c];
      sb.push_back(exp_t'{eg[c], ev[c], es[c], 8'h03});
      tick();
      e = sb.pop_front();
      checks++;
      if (gnt !== e.g || ovalid !== e.v || busy !== (|e.v)) begin
        errors++;
        $display("[TB] FAIL reset_mid c%0d gnt/ovalid/busy got %b/%b/%b want %b/%b/%b", c + 1, gnt, ovalid, busy, e.g, e.v, |e.v);
      end
      checks++;
      if ((osel_all & e.m) !== (e.s & e.m)) begin
        errors++;
        $display("[TB] FAIL reset_mid c%0d osel got %h want %h (mask %h)", c + 1, osel_all, e.s, e.m);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_withdrawal();
    logic [3:0] rq [7];
    logic [3:0] eg [7];
    logic [3:0] ev [7];
    exp_t e;
    rq = '{4'b0001, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    ev = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    do_reset();
    dest0 = 2'd3; len0 = 2'd3; dest2 = 2'd3; len2 = 2'd0;
    for (int c = 0; c < 7; c++) begin
      req = rq[c];
      sb.push_back(exp_t'{eg[c], ev[c], 8'h00, 8'hC0});
      tick();
      e = sb.pop_front();
      checks++;
      if (gnt !== e.g || ovalid !== e.v || busy !== (|e.v)) begin
        errors++;
        $display("[TB] FAIL withdrawal c%0d gnt/ovalid/busy got %b/%b/%b want %b/%b/%b", c + 1, gnt, ovalid, busy, e.g, e.v, |e.v);
      end
      checks++;
      if ((osel_all & e.m) !== (e.s & e.m)) begin
        errors++;
        $display("[TB] FAIL withdrawal c%0d osel got %h want %h (mask %h)", c + 1, osel_all, e.s, e.m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_permutation();
    test_fairness();
    test_reset_mid_packet();
    test_withdrawal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
